// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: ownership state encodings
// and a helper that sizes the saturating counters.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  // Ownership phases of the shared data memory
  typedef enum logic [1:0] {
    ST_CPU_OWN  = 2'b00,
    ST_HANDOVER = 2'b01,
    ST_EXT_OWN  = 2'b10,
    ST_RETURN   = 2'b11
  } arb_state_e;

  // Bits needed to hold 0..max_val without wrapping
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_sat_counter
// Up-counter that saturates at MAX. Synchronous clear has priority over
// increment. RST_VAL selects the value loaded by the asynchronous reset.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear to zero
//   inc_i   increment (held at MAX once reached)
//   out_o   registered count
// -----------------------------------------------------------------------------
module dmem_arbiter_sat_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX     = 8,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned W       = cnt_width(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] out_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step up until MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU datapath and one external
// master using a hold/holdack handshake. The CPU is stalled whenever it does
// not own the memory. External bursts are capped at MAX_BURST cycles while the
// CPU is waiting, and the CPU keeps the memory for at least CPU_SLOT cycles
// after each return before another handover.
// Ports:
//   clk_i, rst_ni                 clock / asynchronous active-low reset
//   cpu_req_i/we_i/a_i/d_i        CPU access request, write enable, addr, data
//   cpu_q_o, cpu_stall_o          CPU read data, stall
//   ext_hold_i, ext_holdack_o     external request / grant
//   ext_we_i/a_i/d_i, ext_q_o     external write enable, addr, data, read data
//   mem_we_o/a_o/d_o, mem_q_i     dmem port (combinational read data)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WIDE      = 32,
  parameter int unsigned AW        = 6,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CPU_SLOT  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cpu_req_i,
  input  logic            cpu_we_i,
  input  logic [AW-1:0]   cpu_a_i,
  input  logic [WIDE-1:0] cpu_d_i,
  output logic [WIDE-1:0] cpu_q_o,
  output logic            cpu_stall_o,
  input  logic            ext_hold_i,
  output logic            ext_holdack_o,
  input  logic            ext_we_i,
  input  logic [AW-1:0]   ext_a_i,
  input  logic [WIDE-1:0] ext_d_i,
  output logic [WIDE-1:0] ext_q_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_a_o,
  output logic [WIDE-1:0] mem_d_o,
  input  logic [WIDE-1:0] mem_q_i
);

  localparam int unsigned BW = cnt_width(MAX_BURST);
  localparam int unsigned SW = cnt_width(CPU_SLOT);

  arb_state_e    state_q;
  logic          holdack_q;
  logic [BW-1:0] burst_cnt_s;
  logic [SW-1:0] slot_cnt_s;
  logic          burst_clr_s;
  logic          burst_inc_s;
  logic          slot_clr_s;
  logic          slot_inc_s;
  logic          slot_full_s;
  logic          burst_last_s;

  // Counter controls derived from the current ownership phase
  always_comb begin
    burst_clr_s  = (state_q == ST_HANDOVER) && ext_hold_i;
    burst_inc_s  = (state_q == ST_EXT_OWN) && cpu_req_i;
    slot_clr_s   = (state_q == ST_RETURN);
    slot_inc_s   = (state_q == ST_CPU_OWN);
    slot_full_s  = (slot_cnt_s == SW'(CPU_SLOT));
    burst_last_s = (burst_cnt_s == BW'(MAX_BURST - 1));
  end

  dmem_arbiter_sat_counter #(
    .MAX     (MAX_BURST),
    .RST_VAL (0),
    .W       (BW)
  ) u_burst_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (burst_clr_s),
    .inc_i  (burst_inc_s),
    .out_o  (burst_cnt_s)
  );

  // Slot counter resets full so the first handover is not delayed
  dmem_arbiter_sat_counter #(
    .MAX     (CPU_SLOT),
    .RST_VAL (CPU_SLOT),
    .W       (SW)
  ) u_slot_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (slot_clr_s),
    .inc_i  (slot_inc_s),
    .out_o  (slot_cnt_s)
  );

  // Ownership FSM with registered grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CPU_OWN;
      holdack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CPU_OWN: begin
          holdack_q <= 1'b0;
          if (ext_hold_i && slot_full_s) begin
            state_q <= ST_HANDOVER;
          end else begin
            state_q <= ST_CPU_OWN;
          end
        end
        ST_HANDOVER: begin
          // A hold that dropped during the handover cycle aborts the grant
          if (ext_hold_i) begin
            state_q   <= ST_EXT_OWN;
            holdack_q <= 1'b1;
          end else begin
            state_q   <= ST_CPU_OWN;
            holdack_q <= 1'b0;
          end
        end
        ST_EXT_OWN: begin
          // Forced release still lets this cycle's external access complete
          if (!ext_hold_i || (cpu_req_i && burst_last_s)) begin
            state_q   <= ST_RETURN;
            holdack_q <= 1'b0;
          end else begin
            state_q   <= ST_EXT_OWN;
            holdack_q <= 1'b1;
          end
        end
        ST_RETURN: begin
          state_q   <= ST_CPU_OWN;
          holdack_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_CPU_OWN;
          holdack_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux; writes are blocked in both transition phases
  always_comb begin
    mem_we_o    = 1'b0;
    mem_a_o     = cpu_a_i;
    mem_d_o     = cpu_d_i;
    cpu_stall_o = cpu_req_i;
    case (state_q)
      ST_CPU_OWN: begin
        mem_we_o    = cpu_req_i & cpu_we_i;
        mem_a_o     = cpu_a_i;
        mem_d_o     = cpu_d_i;
        cpu_stall_o = 1'b0;
      end
      ST_EXT_OWN: begin
        mem_we_o    = ext_we_i;
        mem_a_o     = ext_a_i;
        mem_d_o     = ext_d_i;
        cpu_stall_o = cpu_req_i;
      end
      ST_HANDOVER, ST_RETURN: begin
        mem_we_o    = 1'b0;
        mem_a_o     = cpu_a_i;
        mem_d_o     = cpu_d_i;
        cpu_stall_o = cpu_req_i;
      end
      default: begin
        mem_we_o    = 1'b0;
        mem_a_o     = cpu_a_i;
        mem_d_o     = cpu_d_i;
        cpu_stall_o = cpu_req_i;
      end
    endcase
  end

  assign ext_holdack_o = holdack_q;
  assign cpu_q_o       = mem_q_i;
  assign ext_q_o       = mem_q_i;

endmodule
